// File: rtl/mdu_multicycle_if.sv
// Handshake/data bundle between the E stage and the multi-cycle MDU.
// The master side (pipeline) issues operations; the slave side (MDU)
// reports busy/done and returns HI/LO through md_out.
interface mdu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] md_out;

    modport master (
        output start, op, rs, rt, req,
        input  busy, done, md_out
    );

    modport slave (
        input  start, op, rs, rt, req,
        output busy, done, md_out
    );
endinterface

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Long ops (MULT/MULTU/DIV/DIVU) hold busy for a fixed per-class latency and
// write HI/LO only on the completion edge, pulsing done there.
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (accumulate into {HI,LO}); without it those opcodes behave as NONE.
module mdu_multicycle #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset,
    mdu_multicycle_if.slave bus
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [3:0]         cur_op;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy_r;
    logic               done_r;

    logic               is_mul;
    logic               is_div;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.md_out = (bus.op == OP_MFHI) ? hi :
                        (bus.op == OP_MFLO) ? lo : '0;

    // Classify the incoming opcode into multiply-class and divide-class long ops.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (bus.op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV, OP_DIVU:   is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    // Full-width products; sign- or zero-extend to 2W so the low 2W bits are exact.
    assign prod_s = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
    assign prod_u = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

    // One shared unsigned divider; signed divide works on magnitudes and fixes signs after.
    // The most-negative dividend has magnitude 2^(W-1), so /-1 naturally yields 0x80..0.
    always_comb begin
        div_signed = (cur_op == OP_DIV);
        a_mag      = op_a[WIDTH-1] ? -op_a : op_a;
        b_mag      = op_b[WIDTH-1] ? -op_b : op_b;
        dvd        = div_signed ? a_mag : op_a;
        dvs        = div_signed ? b_mag : op_b;
        if (dvs == '0) begin
            dvs = WIDTH'(1);
        end
        quo = dvd / dvs;
        rem = dvd % dvs;
        if (div_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) begin
            quo = -quo;
        end
        if (div_signed && op_a[WIDTH-1]) begin
            rem = -rem;
        end
    end

    // Select the HI/LO values to commit on the completion edge; divide by zero keeps HI/LO.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (cur_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (op_b != '0) begin
                    res_lo = quo;
                    res_hi = rem;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

    // Control FSM: accept ops in IDLE, count down in BUSY, commit result and pulse done at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            cur_op <= OP_NONE;
            op_a   <= '0;
            op_b   <= '0;
            hi     <= '0;
            lo     <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.req) begin
                        if (is_mul || is_div) begin
                            state  <= BUSY;
                            busy_r <= 1'b1;
                            cur_op <= bus.op;
                            op_a   <= bus.rs;
                            op_b   <= bus.rt;
                            count  <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                        end else if (bus.op == OP_MTHI) begin
                            hi <= bus.rs;
                        end else if (bus.op == OP_MTLO) begin
                            lo <= bus.rs;
                        end
                    end
                end
                BUSY: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        hi     <= res_hi;
                        lo     <= res_lo;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed scenarios plus a randomized
// run against a 64-bit arithmetic model of {HI,LO}. Honours MDU_MADD_EN.
module tb_mdu_multicycle;

    localparam int W     = 32;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [63:0] m_hilo;

    mdu_multicycle_if #(.WIDTH(W)) bus ();

    mdu_multicycle #(
        .WIDTH(W),
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: MIPS semantics expressed with 64-bit integer arithmetic.
    function automatic void model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  m_hilo = 64'(sa * sb);
            OP_MULTU: m_hilo = {32'd0, a} * {32'd0, b};
            OP_DIV:   if (b != 0) m_hilo = {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  if (b != 0) m_hilo = {a % b, a / b};
`ifdef MDU_MADD_EN
            OP_MADD:  m_hilo = m_hilo + 64'(sa * sb);
            OP_MADDU: m_hilo = m_hilo + {32'd0, a} * {32'd0, b};
            OP_MSUB:  m_hilo = m_hilo - 64'(sa * sb);
            OP_MSUBU: m_hilo = m_hilo - {32'd0, a} * {32'd0, b};
`endif
            OP_MTHI:  m_hilo[63:32] = a;
            OP_MTLO:  m_hilo[31:0] = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU: return MUL_N;
            OP_DIV, OP_DIVU:   return DIV_N;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MUL_N;
`endif
            default: return 0;
        endcase
    endfunction

    // Present one op for one clock edge; returns at posedge+1 with start dropped.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs    = a;
        bus.rt    = b;
        bus.req   = r;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.req   = 1'b0;
    endtask

    // Count busy samples from now until busy drops (bounded); report done at that point.
    task automatic wait_idle(output int n, output logic d);
        n = 0;
        d = bus.done;
        if (bus.busy) begin
            n = 1;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                if (bus.busy) begin
                    n++;
                end else begin
                    d = bus.done;
                    break;
                end
            end
        end
    endtask

    // Read HI and LO through md_out between clock edges.
    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        bus.op = OP_MFHI;
        #1;
        h = bus.md_out;
        bus.op = OP_MFLO;
        #1;
        l = bus.md_out;
        bus.op = OP_NONE;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", h, l); end
        @(negedge clk);
        reset  = 1'b0;
        m_hilo = 64'd0;
    endtask

    task automatic test_mult();
        int n; logic d; logic [31:0] h, l;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        model_apply(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_idle(n, d);
        tests_run++; if (n !== MUL_N) begin tests_failed++; $display("[TB] FAIL mult_latency: got %0d expected %0d", n, MUL_N); end
        tests_run++; if (d !== 1'b1) begin tests_failed++; $display("[TB] FAIL mult_done: got %b expected 1", d); end
        @(posedge clk);
        #1;
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_pulse_width: got %b expected 0", bus.done); end
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFA) begin tests_failed++; $display("[TB] FAIL mult_result: got %h_%h expected ffffffff_fffffffa", h, l); end
    endtask

    task automatic test_div_by_zero();
        int n; logic d; logic [31:0] h, l;
        issue(OP_MTHI, 32'h11, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h22, 32'd0, 1'b0);
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mtlo_busy: got %b expected 0", bus.busy); end
        issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
        m_hilo = 64'h00000011_00000022;
        wait_idle(n, d);
        tests_run++; if (n !== DIV_N) begin tests_failed++; $display("[TB] FAIL divz_latency: got %0d expected %0d", n, DIV_N); end
        tests_run++; if (d !== 1'b1) begin tests_failed++; $display("[TB] FAIL divz_done: got %b expected 1", d); end
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'h00000011_00000022) begin tests_failed++; $display("[TB] FAIL divz_hilo: got %h_%h expected 00000011_00000022", h, l); end
    endtask

    task automatic test_div_signed();
        int n; logic d; logic [31:0] h, l;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle(n, d);
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin tests_failed++; $display("[TB] FAIL div_neg7_by_2: got %h_%h expected ffffffff_fffffffd", h, l); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(n, d);
        tests_run++; if (n !== DIV_N) begin tests_failed++; $display("[TB] FAIL div_ovf_latency: got %0d expected %0d", n, DIV_N); end
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'h00000000_80000000) begin tests_failed++; $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", h, l); end
        m_hilo = 64'h00000000_80000000;
    endtask

    task automatic test_req();
        int n; logic d; logic [31:0] h, l;
        issue(OP_MULT, 32'd5, 32'd7, 1'b1);
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL req_squash_busy: got %b expected 0", bus.busy); end
        issue(OP_MTHI, 32'hABCD, 32'd0, 1'b1);
        read_hilo(h, l);
        tests_run++; if ({h, l} !== m_hilo) begin tests_failed++; $display("[TB] FAIL req_squash_hilo: got %h_%h expected %h", h, l, m_hilo); end
        issue(OP_MULTU, 32'h1234, 32'h5678, 1'b0);
        model_apply(OP_MULTU, 32'h1234, 32'h5678);
        repeat (2) @(posedge clk);
        #1;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        wait_idle(n, d);
        tests_run++; if (n !== MUL_N - 3) begin tests_failed++; $display("[TB] FAIL req_busy_remaining: got %0d expected %0d", n, MUL_N - 3); end
        tests_run++; if (d !== 1'b1) begin tests_failed++; $display("[TB] FAIL req_busy_done: got %b expected 1", d); end
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'h00000000_0626_0060) begin tests_failed++; $display("[TB] FAIL req_busy_result: got %h_%h expected 00000000_06260060", h, l); end
    endtask

    task automatic test_reset_midop();
        issue(OP_MTHI, 32'h55, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h66, 32'd0, 1'b0);
        issue(OP_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midop_reset_busy: got %b expected 0", bus.busy); end
        bus.op = OP_MFLO;
        #1;
        tests_run++; if (bus.md_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL midop_reset_lo: got %h expected 0", bus.md_out); end
        bus.op = OP_MFHI;
        #1;
        tests_run++; if (bus.md_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL midop_reset_hi: got %h expected 0", bus.md_out); end
        bus.op = OP_NONE;
        @(negedge clk);
        reset  = 1'b0;
        m_hilo = 64'd0;
        @(posedge clk);
        #1;
        bus.op = OP_MFLO;
        #1;
        tests_run++; if (bus.md_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL after_reset_mflo: got %h expected 0", bus.md_out); end
        bus.op = OP_NONE;
    endtask

    task automatic test_back_to_back();
        int n; logic d; logic [31:0] h, l;
        issue(OP_MULT, 32'h00010003, 32'hFFFF0002, 1'b0);
        model_apply(OP_MULT, 32'h00010003, 32'hFFFF0002);
        issue(OP_MTHI, 32'hDEAD, 32'd0, 1'b0);
        issue(OP_DIVU, 32'd9, 32'd2, 1'b0);
        wait_idle(n, d);
        tests_run++; if (n !== MUL_N - 2) begin tests_failed++; $display("[TB] FAIL b2b_ignored_start: got %0d expected %0d", n, MUL_N - 2); end
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        read_hilo(h, l);
        tests_run++; if ({h, l} !== m_hilo) begin tests_failed++; $display("[TB] FAIL b2b_mult_result: got %h_%h expected %h", h, l, m_hilo); end
        model_apply(OP_DIVU, 32'd100, 32'd7);
        wait_idle(n, d);
        read_hilo(h, l);
        tests_run++; if ({h, l} !== 64'h00000002_0000000E) begin tests_failed++; $display("[TB] FAIL b2b_divu_result: got %h_%h expected 00000002_0000000e", h, l); end
    endtask

    task automatic test_madd();
        int n; logic d; logic [31:0] h, l;
        issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
        issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
        wait_idle(n, d);
        read_hilo(h, l);
`ifdef MDU_MADD_EN
        tests_run++; if (n !== MUL_N) begin tests_failed++; $display("[TB] FAIL maddu_latency: got %0d expected %0d", n, MUL_N); end
        tests_run++; if ({h, l} !== 64'h00000001_00000000) begin tests_failed++; $display("[TB] FAIL maddu_carry: got %h_%h expected 00000001_00000000", h, l); end
        m_hilo = 64'h00000001_00000000;
`else
        tests_run++; if (n !== 0) begin tests_failed++; $display("[TB] FAIL maddu_disabled_busy: got %0d expected 0", n); end
        tests_run++; if (d !== 1'b0) begin tests_failed++; $display("[TB] FAIL maddu_disabled_done: got %b expected 0", d); end
        tests_run++; if ({h, l} !== 64'h00000000_FFFFFFFF) begin tests_failed++; $display("[TB] FAIL maddu_disabled_hilo: got %h_%h expected 00000000_ffffffff", h, l); end
        m_hilo = 64'h00000000_FFFFFFFF;
`endif
    endtask

    task automatic test_random();
        int n; logic d; logic [31:0] h, l, a, b; logic [3:0] o;
        logic [3:0] ops [10] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(9, 0)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(4, 0) == 0) b = 32'd0;
            if ($urandom_range(5, 0) == 0) a = 32'h80000000;
            if ($urandom_range(5, 0) == 0) b = 32'hFFFFFFFF;
            issue(o, a, b, 1'b0);
            model_apply(o, a, b);
            wait_idle(n, d);
            tests_run++; if (n !== exp_latency(o)) begin tests_failed++; $display("[TB] FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, o, n, exp_latency(o)); end
            tests_run++; if (d !== (exp_latency(o) != 0)) begin tests_failed++; $display("[TB] FAIL rand_done[%0d] op=%0d: got %b expected %b", i, o, d, exp_latency(o) != 0); end
            read_hilo(h, l);
            tests_run++; if ({h, l} !== m_hilo) begin tests_failed++; $display("[TB] FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h_%h expected %h", i, o, a, b, h, l, m_hilo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_by_zero();
        test_div_signed();
        test_req();
        test_reset_midop();
        test_back_to_back();
        test_madd();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
